// File: rtl/inv_reg_chain_pkg.sv
// Shared types and defaults for the inversion register chain.
package inv_reg_pkg;

  localparam int INV_M = 16;
  localparam int INV_D = 4;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_FLUSH = 3'd1,
    OP_INIT  = 3'd2,
    OP_ROT   = 3'd3,
    OP_SHIFT = 3'd4
  } op_t;

  function automatic int fill_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/inv_reg_chain_if.sv
// Control, data and status bundle between the inversion datapath and the register chain.
interface inv_reg_chain_if
  import inv_reg_pkg::*;
#(
  parameter int M = INV_M,
  parameter int D = INV_D
);

  localparam int TW = $clog2(D);
  localparam int FW = fill_w(D);

  logic            flush;
  logic            en;
  logic            init;
  logic            rot;
  logic [M-1:0]    reg_in;
  logic [M-1:0]    reg_init;
  logic [TW-1:0]   tap_sel;
  logic [M*D-1:0]  reg_out;
  logic [M-1:0]    tap_out;
  logic [FW-1:0]   fill_cnt;
  logic            full;

  modport master (
    output flush, en, init, rot, reg_in, reg_init, tap_sel,
    input  reg_out, tap_out, fill_cnt, full
  );

  modport slave (
    input  flush, en, init, rot, reg_in, reg_init, tap_sel,
    output reg_out, tap_out, fill_cnt, full
  );

endinterface

// File: rtl/inv_reg_chain_stage.sv
// One M-bit chain stage: async active-low reset, synchronous clear, load enable.
module inv_reg_stage #(
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [M-1:0] d,
  output logic [M-1:0] q
);

  // Stage register; clear outranks load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/inv_reg_chain.sv
// D-stage M-bit shift chain with flush, fill tracking and tap read.
// Rotate mode is built only when INV_REG_CHAIN_ROT_EN is defined.
module inv_reg_chain
  import inv_reg_pkg::*;
#(
  parameter int M = INV_M,
  parameter int D = INV_D
) (
  input logic            clk,
  input logic            rst,
  inv_reg_chain_if.slave bus
);

  localparam int FW = fill_w(D);

  op_t             op;
  logic [M-1:0]    stage [D];
  logic [FW-1:0]   fill_cnt;
  logic [M-1:0]    tap;
  logic            clr;
  logic            ld;
  logic            full;

`ifndef INV_REG_CHAIN_ROT_EN
  logic unused_rot;
  assign unused_rot = bus.rot;
`endif

  // Decode the per-cycle operation once for every stage.
  always_comb begin
    op = OP_HOLD;
    if (bus.flush) begin
      op = OP_FLUSH;
    end else if (bus.en && bus.init) begin
      op = OP_INIT;
`ifdef INV_REG_CHAIN_ROT_EN
    end else if (bus.en && bus.rot) begin
      op = OP_ROT;
`endif
    end else if (bus.en) begin
      op = OP_SHIFT;
    end else begin
      op = OP_HOLD;
    end
  end

  assign clr = (op == OP_FLUSH);
  assign ld  = (op == OP_INIT) || (op == OP_ROT) || (op == OP_SHIFT);

  for (genvar k = 0; k < D; k++) begin : g_stage
    logic [M-1:0] d;

    if (k == 0) begin : g_head
      // Stage 0 takes the seed, the wrapped tail, or the new element.
      always_comb begin
        d = bus.reg_in;
        case (op)
          OP_INIT: d = bus.reg_init;
`ifdef INV_REG_CHAIN_ROT_EN
          OP_ROT:  d = stage[D-1];
`endif
          default: d = bus.reg_in;
        endcase
      end
    end else begin : g_body
      // Later stages take their predecessor, or zero on a re-seed.
      always_comb begin
        if (op == OP_INIT) begin
          d = '0;
        end else begin
          d = stage[k-1];
        end
      end
    end

    inv_reg_stage #(.M(M)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .ld  (ld),
      .d   (d),
      .q   (stage[k])
    );

    assign bus.reg_out[k*M +: M] = stage[k];
  end

  assign full = (fill_cnt == FW'(D));

  // Fill count saturates at D on shifts; rotate and hold leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
    end else begin
      case (op)
        OP_FLUSH: fill_cnt <= '0;
        OP_INIT:  fill_cnt <= FW'(1);
        OP_SHIFT: fill_cnt <= full ? fill_cnt : (fill_cnt + FW'(1));
        default:  fill_cnt <= fill_cnt;
      endcase
    end
  end

  // Tap read; selectors past the last stage read as zero.
  always_comb begin
    tap = '0;
    if (int'(bus.tap_sel) < D) begin
      tap = stage[bus.tap_sel];
    end else begin
      tap = '0;
    end
  end

  assign bus.tap_out  = tap;
  assign bus.fill_cnt = fill_cnt;
  assign bus.full     = full;

endmodule

// File: tb/tb_inv_reg_chain.sv
// Self-checking bench for inv_reg_chain (M=16, D=4) against a queue-based reference model.
module tb_inv_reg_chain;

  localparam int M = 16;
  localparam int D = 4;
`ifdef INV_REG_CHAIN_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [M-1:0] mq[$];
  int           m_fill;

  inv_reg_chain_if #(.M(M), .D(D)) bus ();

  inv_reg_chain #(.M(M), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq = {};
    for (int i = 0; i < D; i++) mq.push_back(16'h0000);
    m_fill = 0;
  endtask

  // Reference behaviour for one rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic [M-1:0] t;
    if (bus.flush) begin
      model_clear();
    end else if (bus.en && bus.init) begin
      mq = {};
      mq.push_back(bus.reg_init);
      for (int i = 1; i < D; i++) mq.push_back(16'h0000);
      m_fill = 1;
    end else if (bus.en && bus.rot && ROT_EN) begin
      t = mq.pop_back();
      mq.push_front(t);
    end else if (bus.en) begin
      t = mq.pop_back();
      mq.push_front(bus.reg_in);
      m_fill = (m_fill < D) ? m_fill + 1 : D;
    end
  endtask

  // Compare every observable output against the model; sweeps tap_sel combinationally.
  task automatic check_state(input string tag);
    logic [M-1:0] saved_sel;
    for (int k = 0; k < D; k++)
      check_eq($sformatf("%s.stage%0d", tag, k), 32'(bus.reg_out[k*M +: M]), 32'(mq[k]));
    check_eq({tag, ".fill_cnt"}, 32'(bus.fill_cnt), 32'(m_fill));
    check_eq({tag, ".full"}, 32'(bus.full), 32'(m_fill == D));
    saved_sel = 16'(bus.tap_sel);
    for (int k = 0; k < D; k++) begin
      bus.tap_sel = 2'(k);
      #1;
      check_eq($sformatf("%s.tap%0d", tag, k), 32'(bus.tap_out), 32'(mq[k]));
    end
    bus.tap_sel = 2'(saved_sel);
  endtask

  task automatic drive(input logic f, input logic e, input logic i, input logic r,
                       input logic [M-1:0] din, input logic [M-1:0] seed);
    bus.flush    = f;
    bus.en       = e;
    bus.init     = i;
    bus.rot      = r;
    bus.reg_in   = din;
    bus.reg_init = seed;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.tap_sel = 2'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    model_clear();

    // Reset state
    #12;
    check_state("reset");
    rst = 1'b1;

    // Load data, then pulse reset mid-cycle
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5A5A);
    cycle("pre_rst_init");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
    cycle("pre_rst_shift");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    model_clear();
    check_eq("async_rst.reg_out", 32'(bus.reg_out[31:0]), 32'h0);
    check_eq("async_rst.reg_out_hi", 32'(bus.reg_out[63:32]), 32'h0);
    check_eq("async_rst.fill_cnt", 32'(bus.fill_cnt), 32'd0);
    check_eq("async_rst.full", 32'(bus.full), 32'd0);
    rst = 1'b1;
    cycle("post_rst_hold");

    // Init then three shifts
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
    cycle("init");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hA001, 16'h0000);
    cycle("shift1");
    bus.reg_in = 16'hA002;
    cycle("shift2");
    bus.reg_in = 16'hA003;
    cycle("shift3");
    check_eq("plan.stage0", 32'(bus.reg_out[15:0]),  32'h0000A003);
    check_eq("plan.stage3", 32'(bus.reg_out[63:48]), 32'h00001234);
    check_eq("plan.full",   32'(bus.full),           32'd1);
    bus.reg_in = 16'hA004;
    cycle("shift4");
    check_eq("plan.drop",   32'(bus.reg_out[63:48]), 32'h0000A001);
    check_eq("plan.fill",   32'(bus.fill_cnt),       32'd4);

    // Hold for five cycles
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    for (int n = 0; n < 5; n++) cycle($sformatf("hold%0d", n));
    bus.tap_sel = 2'd1;
    #1;
    check_eq("plan.tap1", 32'(bus.tap_out), 32'h0000A003);

    // Priority: flush over init
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, 16'h8888);
    cycle("flush_prio");
    check_eq("plan.flush_fill", 32'(bus.fill_cnt), 32'd0);

    // Priority: init over rot
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h7777, 16'h4321);
    cycle("init_over_rot");
    check_eq("plan.init_rot", 32'(bus.reg_out[15:0]), 32'h00004321);

    // Build {4,3,2,1} then rotate / shift
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000);
    for (int n = 1; n <= D; n++) begin
      bus.reg_in = 16'(n);
      cycle($sformatf("fill%0d", n));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000);
    cycle("rot1");
    check_eq("plan.rot_s0", 32'(bus.reg_out[15:0]), ROT_EN ? 32'h1 : 32'hFF);
    check_eq("plan.rot_s1", 32'(bus.reg_out[31:16]), 32'h4);
    if (ROT_EN) begin
      for (int n = 0; n < D - 1; n++) cycle($sformatf("rot%0d", n + 2));
      check_eq("plan.rot_restore", 32'(bus.reg_out[15:0]), 32'h4);
    end

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            1'($urandom), 16'($urandom), 16'($urandom));
      bus.tap_sel = 2'($urandom);
      cycle($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
